address_router: RTL and testbench
=================================

ADDRESS_ROUTER -- requirements
Module: address_router

Interface
REQ-001 Parameter: num_slaves, default 5, number of slave address-channel ports (1..8).
REQ-002 Ports: clk input 1, single clock; all state on rising edge.
REQ-003 Ports: reset input 1, asynchronous, active-low.
REQ-004 Ports: m_addr input 32, master address.
REQ-005 Ports: m_len input 8, burst length.
REQ-006 Ports: m_size input 3, beat size.
REQ-007 Ports: m_burst input 2, burst type.
REQ-008 Ports: m_valid input 1, master request valid.
REQ-009 Ports: m_ready output 1, router can accept a request.
REQ-010 Ports: s_addr output num_slaves x 32, packed per-slave address.
REQ-011 Ports: s_len output num_slaves x 8, packed per-slave length.
REQ-012 Ports: s_size output num_slaves x 3, packed per-slave size.
REQ-013 Ports: s_burst output num_slaves x 2, packed per-slave burst.
REQ-014 Ports: s_valid output num_slaves, per-slave valid.
REQ-015 Ports: s_ready input num_slaves, per-slave ready.
REQ-016 Ports: slave input 3, target slave index for the current request.
REQ-017 Ports: sel_q output 3, registered index of the last accepted request.

Function
REQ-018 The block SHALL be a one-entry holding stage with two states: IDLE (empty) and BUSY (holding a request).
REQ-019 In IDLE, m_ready SHALL be 1; in BUSY, m_ready SHALL be 0 unless REQ-031 applies.
REQ-020 On a rising edge with m_valid=1 and m_ready=1, the block SHALL capture m_addr, m_len, m_size, m_burst and slave, load sel_q with slave, and enter BUSY.
REQ-021 In BUSY with sel_q < num_slaves, s_valid[sel_q] SHALL be 1, and s_addr/s_len/s_size/s_burst[sel_q] SHALL carry the captured fields.
REQ-022 All non-selected slave lanes, and all lanes in IDLE, SHALL drive s_valid=0 and zero address, length, size and burst fields.
REQ-023 Forwarding latency SHALL be exactly one cycle: s_valid asserts in the cycle after master acceptance.
REQ-024 When s_valid[sel_q]=1 and s_ready[sel_q]=1 on a rising edge, the transfer SHALL complete and the block SHALL return to IDLE.
REQ-025 While s_ready[sel_q]=0, the block SHALL hold s_valid and all fields stable for an unbounded time; m_valid deasserting has no effect.
REQ-026 A request with slave >= num_slaves SHALL be accepted and loaded into sel_q, assert no s_valid, and be dropped, with a return to IDLE on the next edge.
REQ-027 After completion, sel_q SHALL hold its value until the next acceptance.
REQ-028 s_ready bits of non-selected slaves SHALL be ignored.

Reset
REQ-029 While reset=0, the block SHALL be forced to IDLE and drive sel_q=0, s_valid=0, all s_* fields=0 and m_ready=0, asynchronously.
REQ-030 Reset asserted mid-transfer SHALL discard the held request; after reset release, m_ready SHALL be 1 from the first edge.

Configuration
REQ-031 With macro ADDRESS_ROUTER_PASSTHRU_READY_EN defined, m_ready SHALL also be 1 in BUSY when s_ready[sel_q]=1 or sel_q >= num_slaves, allowing a new acceptance on the completing edge (back-to-back, one request per cycle); without the macro, a new request is accepted only in IDLE, giving a maximum of one request per two cycles.

Verification
REQ-032 Scenario: after reset, slave=0, m_addr=0x00000010, m_len=7, m_size=2, m_burst=1, 1-cycle m_valid, s_ready all 1 -> sel_q=0, s_valid=5'b00001 for one cycle, s_addr[0]=0x00000010, then IDLE.
REQ-033 Scenario: s_ready[3]=0, slave=3, m_addr=0xF0010004, 1-cycle m_valid -> s_valid=5'b01000 held with m_ready=0 until s_ready[3]=1, then complete and m_ready=1.
REQ-034 Scenario: slave=1, m_addr=0x20001000 -> sel_q=1, s_valid=5'b00010, s_addr[1]=0x20001000, s_addr[0]=0.
REQ-035 Scenario: slave=6 -> sel_q=6, s_valid stays 0, m_ready returns to 1 after one cycle.
REQ-036 Scenario: reset asserted while BUSY on slave 3 -> s_valid=0 and sel_q=0 immediately without waiting for a clock.
REQ-037 Scenario: with ADDRESS_ROUTER_PASSTHRU_READY_EN defined, m_valid held high for slaves 0, 1, 2 with all ready -> one acceptance per cycle; without the macro -> one acceptance per two cycles.

Source files
------------

// File: rtl/address_router.sv
// One-entry address-channel holding stage that routes a master request to one of num_slaves lanes.
// Optional ADDRESS_ROUTER_PASSTHRU_READY_EN lets a new request be accepted on the completing edge.
module address_router #(
   parameter int unsigned num_slaves = 5
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic [31:0]             m_addr,
   input  logic [7:0]              m_len,
   input  logic [2:0]              m_size,
   input  logic [1:0]              m_burst,
   input  logic                    m_valid,
   output logic                    m_ready,
   output logic [num_slaves*32-1:0] s_addr,
   output logic [num_slaves*8-1:0]  s_len,
   output logic [num_slaves*3-1:0]  s_size,
   output logic [num_slaves*2-1:0]  s_burst,
   output logic [num_slaves-1:0]    s_valid,
   input  logic [num_slaves-1:0]    s_ready,
   input  logic [2:0]               slave,
   output logic [2:0]               sel_q
);

   typedef enum logic {IDLE, BUSY} state_t;

   state_t      state;
   logic [31:0] addr_q;
   logic [7:0]  len_q;
   logic [2:0]  size_q;
   logic [1:0]  burst_q;
   logic        sel_in_range;
   logic        sel_ready;
   logic        lane_done;
   logic        accept;

   // Lane lookup by loop keeps s_ready indexing in range when sel_q >= num_slaves.
   always_comb begin
      sel_in_range = 1'b0;
      sel_ready    = 1'b0;
      for (int unsigned i = 0; i < num_slaves; i++) begin
         if (sel_q == 3'(i)) begin
            sel_in_range = 1'b1;
            sel_ready    = s_ready[i];
         end
      end
   end

   assign lane_done = (state == BUSY) && (!sel_in_range || sel_ready);

`ifdef ADDRESS_ROUTER_PASSTHRU_READY_EN
   assign m_ready = reset && ((state == IDLE) || lane_done);
`else
   assign m_ready = reset && (state == IDLE);
`endif

   assign accept = m_valid && m_ready;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state   <= IDLE;
         sel_q   <= '0;
         addr_q  <= '0;
         len_q   <= '0;
         size_q  <= '0;
         burst_q <= '0;
      end else begin
         if (accept) begin
            sel_q   <= slave;
            addr_q  <= m_addr;
            len_q   <= m_len;
            size_q  <= m_size;
            burst_q <= m_burst;
         end
         case (state)
            IDLE:    if (accept) state <= BUSY;
            BUSY:    if (lane_done && !accept) state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

   always_comb begin
      s_valid = '0;
      s_addr  = '0;
      s_len   = '0;
      s_size  = '0;
      s_burst = '0;
      if (state == BUSY) begin
         for (int unsigned i = 0; i < num_slaves; i++) begin
            if (sel_q == 3'(i)) begin
               s_valid[i]         = 1'b1;
               s_addr[i*32 +: 32] = addr_q;
               s_len[i*8 +: 8]    = len_q;
               s_size[i*3 +: 3]   = size_q;
               s_burst[i*2 +: 2]  = burst_q;
            end
         end
      end
   end

endmodule

// File: tb/tb_address_router.sv
// Bench for address_router: directed table, reset/throughput sequences and random traffic
// checked against a queue-based model of the one-entry holding stage.
module tb_address_router;

   localparam int N = 5;
`ifdef ADDRESS_ROUTER_PASSTHRU_READY_EN
   localparam bit PT = 1'b1;
`else
   localparam bit PT = 1'b0;
`endif

   logic           clk = 1'b0;
   logic           reset = 1'b0;
   logic [31:0]    m_addr = '0;
   logic [7:0]     m_len = '0;
   logic [2:0]     m_size = '0;
   logic [1:0]     m_burst = '0;
   logic           m_valid = 1'b0;
   logic           m_ready;
   logic [N*32-1:0] s_addr;
   logic [N*8-1:0]  s_len;
   logic [N*3-1:0]  s_size;
   logic [N*2-1:0]  s_burst;
   logic [N-1:0]    s_valid;
   logic [N-1:0]    s_ready = '0;
   logic [2:0]      slave = '0;
   logic [2:0]      sel_q;

   always #5 clk = ~clk;

   address_router #(.num_slaves(N)) dut (
      .clk(clk), .reset(reset), .m_addr(m_addr), .m_len(m_len), .m_size(m_size),
      .m_burst(m_burst), .m_valid(m_valid), .m_ready(m_ready), .s_addr(s_addr),
      .s_len(s_len), .s_size(s_size), .s_burst(s_burst), .s_valid(s_valid),
      .s_ready(s_ready), .slave(slave), .sel_q(sel_q)
   );

   typedef struct {
      logic [2:0]  sl;
      logic [31:0] a;
      logic [7:0]  l;
      logic [2:0]  sz;
      logic [1:0]  b;
   } req_t;

   typedef struct {
      logic        v;
      logic [2:0]  sl;
      logic [31:0] a;
      logic [7:0]  l;
      logic [2:0]  sz;
      logic [1:0]  b;
      logic [4:0]  rdy;
      logic        e_mr;
      logic [4:0]  e_sv;
      logic [2:0]  e_sel;
      logic [31:0] e_a;
      logic [7:0]  e_l;
      logic [2:0]  e_sz;
      logic [1:0]  e_b;
   } vec_t;

   req_t       q[$];
   logic [2:0] m_sel = '0;
   int         vectors = 0;
   int         miscompares = 0;
   vec_t       tbl[12];

   task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic bit head_done();
      if (int'(q[0].sl) >= N) return 1'b1;
      return s_ready[q[0].sl];
   endfunction

   function automatic bit model_mready();
      if (!reset) return 1'b0;
      if (q.size() == 0) return 1'b1;
      return PT && head_done();
   endfunction

   // One rising edge of the held request queue, using the inputs driven during the last cycle.
   task automatic model_edge();
      bit   acc;
      req_t r;
      acc = m_valid && model_mready();
      if (q.size() > 0 && head_done()) q.delete(0);
      if (acc) begin
         r.sl = slave; r.a = m_addr; r.l = m_len; r.sz = m_size; r.b = m_burst;
         q.push_back(r);
         m_sel = slave;
      end
   endtask

   task automatic compare_all();
      logic [N*32-1:0] ea;
      logic [N*8-1:0]  el;
      logic [N*3-1:0]  esz;
      logic [N*2-1:0]  eb;
      logic [N-1:0]    ev;
      ea = '0; el = '0; esz = '0; eb = '0; ev = '0;
      if (q.size() > 0 && int'(q[0].sl) < N) begin
         ev[q[0].sl]         = 1'b1;
         ea[q[0].sl*32 +: 32] = q[0].a;
         el[q[0].sl*8 +: 8]   = q[0].l;
         esz[q[0].sl*3 +: 3]  = q[0].sz;
         eb[q[0].sl*2 +: 2]   = q[0].b;
      end
      check("m_ready", m_ready, model_mready());
      check("s_valid", s_valid, ev);
      check("sel_q", sel_q, m_sel);
      check("s_addr", s_addr, ea);
      check("s_len", s_len, el);
      check("s_size", s_size, esz);
      check("s_burst", s_burst, eb);
   endtask

   task automatic cycle(input logic v, input logic [2:0] sl, input logic [31:0] a,
                        input logic [7:0] l, input logic [2:0] sz, input logic [1:0] b,
                        input logic [N-1:0] rdy);
      @(negedge clk);
      model_edge();
      m_valid = v; slave = sl; m_addr = a; m_len = l; m_size = sz; m_burst = b; s_ready = rdy;
      #1;
      compare_all();
   endtask

   task automatic check_row(input int idx, input vec_t r);
      logic [N*32-1:0] ea;
      logic [N*8-1:0]  el;
      logic [N*3-1:0]  esz;
      logic [N*2-1:0]  eb;
      ea = '0; el = '0; esz = '0; eb = '0;
      if (r.e_sv != '0) begin
         ea[r.e_sel*32 +: 32] = r.e_a;
         el[r.e_sel*8 +: 8]   = r.e_l;
         esz[r.e_sel*3 +: 3]  = r.e_sz;
         eb[r.e_sel*2 +: 2]   = r.e_b;
      end
      check($sformatf("row%0d_m_ready", idx), m_ready, r.e_mr);
      check($sformatf("row%0d_s_valid", idx), s_valid, r.e_sv);
      check($sformatf("row%0d_sel_q", idx), sel_q, r.e_sel);
      check($sformatf("row%0d_s_addr", idx), s_addr, ea);
      check($sformatf("row%0d_s_fields", idx), {s_len, s_size, s_burst}, {el, esz, eb});
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout required completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int k;
      int cyc;
      //          v   sl    addr          len   sz    b     rdy       e_mr  e_sv      sel   e_addr        e_len e_sz  e_b
      tbl[0]  = '{1'b1, 3'd0, 32'h00000010, 8'd7, 3'd2, 2'd1, 5'b11111, 1'b1, 5'b00000, 3'd0, 32'h0,        8'd0, 3'd0, 2'd0};
      tbl[1]  = '{1'b0, 3'd0, 32'h0,        8'd0, 3'd0, 2'd0, 5'b11111, PT,   5'b00001, 3'd0, 32'h00000010, 8'd7, 3'd2, 2'd1};
      tbl[2]  = '{1'b0, 3'd0, 32'h0,        8'd0, 3'd0, 2'd0, 5'b11111, 1'b1, 5'b00000, 3'd0, 32'h0,        8'd0, 3'd0, 2'd0};
      tbl[3]  = '{1'b1, 3'd3, 32'hF0010004, 8'd3, 3'd2, 2'd1, 5'b10111, 1'b1, 5'b00000, 3'd0, 32'h0,        8'd0, 3'd0, 2'd0};
      tbl[4]  = '{1'b0, 3'd0, 32'h0,        8'd0, 3'd0, 2'd0, 5'b10111, 1'b0, 5'b01000, 3'd3, 32'hF0010004, 8'd3, 3'd2, 2'd1};
      tbl[5]  = '{1'b1, 3'd1, 32'h11111111, 8'd9, 3'd1, 2'd0, 5'b10111, 1'b0, 5'b01000, 3'd3, 32'hF0010004, 8'd3, 3'd2, 2'd1};
      tbl[6]  = '{1'b0, 3'd0, 32'h0,        8'd0, 3'd0, 2'd0, 5'b11111, PT,   5'b01000, 3'd3, 32'hF0010004, 8'd3, 3'd2, 2'd1};
      tbl[7]  = '{1'b1, 3'd1, 32'h20001000, 8'd0, 3'd2, 2'd1, 5'b11111, 1'b1, 5'b00000, 3'd3, 32'h0,        8'd0, 3'd0, 2'd0};
      tbl[8]  = '{1'b0, 3'd0, 32'h0,        8'd0, 3'd0, 2'd0, 5'b11111, PT,   5'b00010, 3'd1, 32'h20001000, 8'd0, 3'd2, 2'd1};
      tbl[9]  = '{1'b1, 3'd6, 32'hDEAD0000, 8'd4, 3'd3, 2'd2, 5'b11111, 1'b1, 5'b00000, 3'd1, 32'h0,        8'd0, 3'd0, 2'd0};
      tbl[10] = '{1'b0, 3'd0, 32'h0,        8'd0, 3'd0, 2'd0, 5'b11111, PT,   5'b00000, 3'd6, 32'h0,        8'd0, 3'd0, 2'd0};
      tbl[11] = '{1'b0, 3'd0, 32'h0,        8'd0, 3'd0, 2'd0, 5'b11111, 1'b1, 5'b00000, 3'd6, 32'h0,        8'd0, 3'd0, 2'd0};

      #2;
      compare_all();
      repeat (3) @(negedge clk);
      reset = 1'b1;

      foreach (tbl[i]) begin
         cycle(tbl[i].v, tbl[i].sl, tbl[i].a, tbl[i].l, tbl[i].sz, tbl[i].b, tbl[i].rdy);
         check_row(i, tbl[i]);
      end

      // Asynchronous reset while holding a request for a stalled slave 3.
      cycle(1'b1, 3'd3, 32'hCAFE0003, 8'd15, 3'd2, 2'd1, 5'b10111);
      cycle(1'b0, 3'd0, 32'h0, 8'd0, 3'd0, 2'd0, 5'b10111);
      check("busy_before_reset", s_valid, 5'b01000);
      #2;
      reset = 1'b0;
      #1;
      q.delete();
      m_sel = '0;
      check("async_rst_s_valid", s_valid, '0);
      check("async_rst_sel_q", sel_q, '0);
      check("async_rst_m_ready", m_ready, 1'b0);
      check("async_rst_s_addr", s_addr, '0);
      @(negedge clk);
      reset = 1'b1;
      #1;
      check("post_rst_m_ready", m_ready, 1'b1);
      cycle(1'b0, 3'd0, 32'h0, 8'd0, 3'd0, 2'd0, 5'b11111);

      // Throughput with m_valid held high and every slave ready.
      k = 0;
      cyc = 0;
      while (k < 3 && cyc < 20) begin
         cycle(1'b1, 3'(k), 32'h1000 * k + 32'h40, 8'(k), 3'd2, 2'd1, '1);
         cyc++;
         if (m_ready) k++;
      end
      check("three_accepts", k, 3);
      check("throughput_cycles", cyc, PT ? 3 : 5);
      repeat (3) cycle(1'b0, 3'd0, 32'h0, 8'd0, 3'd0, 2'd0, '1);

      for (int i = 0; i < 400; i++) begin
         cycle($urandom_range(0, 3) != 0, 3'($urandom_range(0, 7)), $urandom,
               8'($urandom), 3'($urandom), 2'($urandom), N'($urandom));
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
